// File: rtl/dct4x4_ctrl.sv
// dct4x4_ctrl: sequences a shared 4-point DCT core into a 4x4 2-D forward DCT.
// A block of 16 row-major samples is buffered, transformed row-wise into a
// transpose buffer, transformed column-wise back into the input buffer, and
// then streamed out row-major. Only one block is in flight at a time.
module dct4x4_ctrl #(
  parameter int CORE_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [32:0] out_data,
  output logic        out_last,
  output logic        core_start,
  output logic [32:0] core_x0,
  output logic [32:0] core_x1,
  output logic [32:0] core_x2,
  output logic [32:0] core_x3,
  input  logic [32:0] core_y0,
  input  logic [32:0] core_y1,
  input  logic [32:0] core_y2,
  input  logic [32:0] core_y3,
  output logic        busy
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_ROW  = 2'd1;
  localparam logic [1:0] S_COL  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  // Sub-cycle counter spans 0..CORE_LAT; keep at least one bit for CORE_LAT=0.
  localparam int              SUB_W    = (CORE_LAT > 0) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CORE_LAT);

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;    // sample index in LOAD, beat index in OUT
  logic [1:0]       r_step;   // row/column being transformed
  logic [SUB_W-1:0] r_sub;    // cycles spent on the current 1-D transform

  // X holds the input block and, after the column pass, the result block.
  logic [32:0] r_x [16];
  // T holds the row-pass results, indexed [row*4 + col].
  logic [32:0] r_t [16];

  logic        w_in_compute;
  logic        w_capture;
  logic        w_load_fire;
  logic        w_out_fire;
  logic [32:0] w_y  [4];
  logic [32:0] w_cx [4];

  assign w_y[0] = core_y0;
  assign w_y[1] = core_y1;
  assign w_y[2] = core_y2;
  assign w_y[3] = core_y3;

  assign w_in_compute = (r_state == S_ROW) || (r_state == S_COL);
  // The core result is taken on the edge ending the last hold cycle.
  assign w_capture    = w_in_compute && (r_sub == SUB_LAST);
  assign w_load_fire  = in_ready && in_valid;
  assign w_out_fire   = out_valid && out_ready;

  // Handshake and status outputs decode from state only (plus reset gating).
  assign in_ready   = (r_state == S_LOAD) && !rst;
  assign out_valid  = (r_state == S_OUT);
  assign out_last   = out_valid && (r_cnt == 4'd15);
  assign out_data   = out_valid ? r_x[r_cnt] : '0;
  assign core_start = w_in_compute && (r_sub == '0);
  assign busy       = (r_state != S_LOAD);

  // Select core operands: a row of X in ROW, a column of T in COL, else zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    for (int i = 0; i < 4; i++) begin
      w_cx[i] = '0;
    end
    if (r_state == S_ROW) begin
      for (int i = 0; i < 4; i++) begin
        w_cx[i] = r_x[{r_step, 2'(i)}];
      end
    end else if (r_state == S_COL) begin
      for (int i = 0; i < 4; i++) begin
        w_cx[i] = r_t[{2'(i), r_step}];
      end
    end
  end

  assign core_x0 = w_cx[0];
  assign core_x1 = w_cx[1];
  assign core_x2 = w_cx[2];
  assign core_x3 = w_cx[3];

  // Sequencer: LOAD -> ROW x4 -> COL x4 -> OUT x16 -> LOAD.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= S_LOAD;
      r_cnt   <= 4'd0;
      r_step  <= 2'd0;
      r_sub   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_load_fire) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= S_ROW;
              r_step  <= 2'd0;
              r_sub   <= '0;
            end
          end
        end
        S_ROW, S_COL: begin
          if (w_capture) begin
            r_sub  <= '0;
            r_step <= r_step + 2'd1;
            if (r_step == 2'd3) begin
              r_state <= (r_state == S_ROW) ? S_COL : S_OUT;
              r_cnt   <= 4'd0;
            end
          end else begin
            r_sub <= r_sub + 1'b1;
          end
        end
        S_OUT: begin
          if (w_out_fire) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'd15) begin
              r_state <= S_LOAD;
            end
          end
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  // Buffer writes: samples into X, row results into T, column results into X.
  always_ff @(posedge clk) begin
    // NOTE: the buffers are plain storage with no reset; a new block always overwrites every entry before it is read.
    if (w_load_fire) begin
      r_x[r_cnt] <= in_data;
    end
    if (w_capture && (r_state == S_ROW)) begin
      for (int i = 0; i < 4; i++) begin
        r_t[{r_step, 2'(i)}] <= w_y[i];
      end
    end
    if (w_capture && (r_state == S_COL)) begin
      for (int i = 0; i < 4; i++) begin
        r_x[{2'(i), r_step}] <= w_y[i];
      end
    end
  end

endmodule

// File: tb/tb_dct4x4_ctrl.sv
// Bench for dct4x4_ctrl: one combinational-core instance (identity, reverse
// or real DCT stub) and one CORE_LAT=2 instance with a 2-cycle identity stub,
// sharing the source/sink stimulus. A scoreboard queue per instance is filled
// at load time and drained by a negedge monitor.
module tb_dct4x4_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic [32:0] in_data;
  logic        out_ready;
  int          mode;      // stub for instance 0: 0 identity, 1 reverse, 2 dct
  bit          stall_en;
  bit [15:0]   done_mask;
  int          cyc = 0;

  always @(posedge clk) cyc++;

  logic        ir [2], ov [2], ol [2], cs [2], bz [2];
  logic [32:0] od [2];
  logic [32:0] cx0 [4], cy0 [4], cx1 [4], cy1 [4];
  logic [131:0] cxall [2];
  logic [131:0] p1, p2;

  dct4x4_ctrl #(.CORE_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]),
    .core_start(cs[0]), .core_x0(cx0[0]), .core_x1(cx0[1]), .core_x2(cx0[2]), .core_x3(cx0[3]),
    .core_y0(cy0[0]), .core_y1(cy0[1]), .core_y2(cy0[2]), .core_y3(cy0[3]), .busy(bz[0])
  );

  dct4x4_ctrl #(.CORE_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]),
    .core_start(cs[1]), .core_x0(cx1[0]), .core_x1(cx1[1]), .core_x2(cx1[2]), .core_x3(cx1[3]),
    .core_y0(cy1[0]), .core_y1(cy1[1]), .core_y2(cy1[2]), .core_y3(cy1[3]), .busy(bz[1])
  );

  assign cxall[0] = {cx0[3], cx0[2], cx0[1], cx0[0]};
  assign cxall[1] = {cx1[3], cx1[2], cx1[1], cx1[0]};

  // ---------------- stub cores ----------------
  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real to_r(input logic [32:0] w);
    real r;
    if (w[23:0] == 24'd0) return 0.0;
    r = real'(w[23:0]) * pow2(int'(w[31:24]) - 150);
    return w[32] ? -r : r;
  endfunction

  function automatic logic [32:0] to_w(input real v);
    real a;
    int  e;
    logic s;
    logic [23:0] m;
    if (v == 0.0) return 33'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 150;
    while (a >= 16777216.0) begin a = a / 2.0; e++; end
    while (a < 8388608.0)   begin a = a * 2.0; e--; end
    m = 24'($rtoi(a));
    return {s, e[7:0], m};
  endfunction

  function automatic logic [32:0] stub_out(input int md, input int k,
      input logic [32:0] a, input logic [32:0] b, input logic [32:0] c, input logic [32:0] d);
    real x0, x1, x2, x3, y;
    if (md == 0) return (k == 0) ? a : (k == 1) ? b : (k == 2) ? c : d;
    if (md == 1) return (k == 0) ? d : (k == 1) ? c : (k == 2) ? b : a;
    x0 = to_r(a); x1 = to_r(b); x2 = to_r(c); x3 = to_r(d);
    case (k)
      0:       y = x0 + x1 + x2 + x3;
      1:       y = 0.9238795325 * (x0 - x3) + 0.3826834324 * (x1 - x2);
      2:       y = 0.7071067812 * (x0 - x1 - x2 + x3);
      default: y = 0.3826834324 * (x0 - x3) - 0.9238795325 * (x1 - x2);
    endcase
    return to_w(y);
  endfunction

  assign cy0[0] = stub_out(mode, 0, cx0[0], cx0[1], cx0[2], cx0[3]);
  assign cy0[1] = stub_out(mode, 1, cx0[0], cx0[1], cx0[2], cx0[3]);
  assign cy0[2] = stub_out(mode, 2, cx0[0], cx0[1], cx0[2], cx0[3]);
  assign cy0[3] = stub_out(mode, 3, cx0[0], cx0[1], cx0[2], cx0[3]);

  // Two-cycle identity core for the CORE_LAT=2 instance.
  always @(posedge clk) begin
    p1 <= cxall[1];
    p2 <= p1;
  end
  assign cy1[0] = p2[32:0];
  assign cy1[1] = p2[65:33];
  assign cy1[2] = p2[98:66];
  assign cy1[3] = p2[131:99];

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  int          lat [2] = '{0, 2};
  int          lcnt [2] = '{0, 0};
  int          bcnt [2] = '{0, 0};
  int          cs_cnt [2] = '{0, 0};
  int          cs_last [2] = '{0, 0};
  int          a_cyc [2] = '{0, 0};
  bit          in_flight [2] = '{0, 0};
  bit          first_pend [2] = '{0, 0};
  bit          prev_stall [2] = '{0, 0};
  logic [32:0] prev_od [2];
  logic        prev_ol [2];
  bit          prev_rst = 1'b0;

  task automatic monitor_step(input int d);
    logic [32:0] e;
    bit          have;
    if (rst) begin
      if (d == 0) q0.delete(); else q1.delete();
      lcnt[d] = 0; bcnt[d] = 0; cs_cnt[d] = 0;
      in_flight[d] = 0; first_pend[d] = 0; prev_stall[d] = 0;
      return;
    end
    if (prev_rst) begin
      check($sformatf("after_rst_ready%0d", d), ir[d], 1);
      check($sformatf("after_rst_valid%0d", d), ov[d], 0);
      check($sformatf("after_rst_busy%0d", d), bz[d], 0);
      check($sformatf("after_rst_start%0d", d), cs[d], 0);
    end
    if (in_flight[d]) check($sformatf("ready_busy_inflight%0d", d), {ir[d], bz[d]}, 2'b01);
    else              check($sformatf("core_x_idle%0d", d), cxall[d], 0);
    if (cs[d]) begin
      check($sformatf("start_inflight%0d", d), in_flight[d], 1);
      if (cs_cnt[d] > 0) check($sformatf("start_spacing%0d", d), cyc - cs_last[d], lat[d] + 1);
      cs_cnt[d]++;
      cs_last[d] = cyc;
    end
    if (ov[d]) begin
      check($sformatf("valid_inflight%0d", d), in_flight[d], 1);
      if (first_pend[d]) begin
        check($sformatf("first_valid_latency%0d", d), cyc - a_cyc[d], 8 * (lat[d] + 1));
        first_pend[d] = 0;
      end
      if (prev_stall[d]) check($sformatf("stall_stable%0d", d), {od[d], ol[d]}, {prev_od[d], prev_ol[d]});
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) fail_now($sformatf("unexpected_beat%0d", d));
      else begin
        e = (d == 0) ? q0[0] : q1[0];
        check($sformatf("beat%0d_data%0d", bcnt[d], d), od[d], e);
      end
      check($sformatf("beat%0d_last%0d", bcnt[d], d), ol[d], (bcnt[d] == 15));
      prev_stall[d] = !out_ready;
      prev_od[d] = od[d];
      prev_ol[d] = ol[d];
      if (out_ready) begin
        if (have) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        bcnt[d]++;
        if (bcnt[d] == 16) begin
          check($sformatf("start_count%0d", d), cs_cnt[d], 8);
          in_flight[d] = 0;
          bcnt[d] = 0;
        end
      end
    end else begin
      prev_stall[d] = 0;
    end
    if (in_valid && ir[d]) begin
      lcnt[d]++;
      if (lcnt[d] == 16) begin
        lcnt[d] = 0; bcnt[d] = 0; cs_cnt[d] = 0;
        in_flight[d] = 1; first_pend[d] = 1;
        a_cyc[d] = cyc + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) monitor_step(d);
    prev_rst = rst;
  end

  // Sink: optionally stalls 5 cycles at beats 0, 7 and 15 of instance 0.
  initial begin
    int stall_left = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left == 0 && stall_en && ov[0] &&
          (bcnt[0] == 0 || bcnt[0] == 7 || bcnt[0] == 15) && !done_mask[bcnt[0]]) begin
        stall_left = 5;
        done_mask[bcnt[0]] = 1'b1;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [32:0] blk [16];
  logic [32:0] exp0 [16];

  task automatic wait_idle();
    int t = 0;
    while (!(ir[0] && ir[1] && q0.size() == 0 && q1.size() == 0)) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 2000) begin
        fail_now("idle_timeout");
        return;
      end
    end
  endtask

  task automatic run_block(input bit gaps);
    wait_idle();
    done_mask = '0;
    for (int n = 0; n < 16; n++) begin
      q0.push_back(exp0[n]);
      q1.push_back(blk[n]);
    end
    for (int n = 0; n < 16; n++) begin
      if (gaps) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = blk[n];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic set_ramp(input bit rev);
    for (int n = 0; n < 16; n++) begin
      blk[n]  = {1'b0, 8'h80, 24'(n)};
      exp0[n] = {1'b0, 8'h80, rev ? 24'(15 - n) : 24'(n)};
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 0; stall_en = 1'b0; done_mask = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Identity core: beat n carries m = n.
    mode = 0; set_ramp(0); run_block(0);

    // Reverse core: beat n carries m = 15-n.
    wait_idle(); mode = 1; set_ramp(1); run_block(0);

    // Real DCT, all inputs +2.5: DC = 16*2.5 = 40 = {0, 8'h84, 24'hA00000}.
    wait_idle(); mode = 2;
    for (int n = 0; n < 16; n++) begin
      blk[n]  = {1'b0, 8'h80, 24'hA00000};
      exp0[n] = 33'd0;
    end
    exp0[0] = {1'b0, 8'h84, 24'hA00000};
    run_block(0);

    // Input gaps and output backpressure.
    wait_idle(); mode = 0; set_ramp(0); stall_en = 1'b1;
    run_block(1);
    wait_idle(); stall_en = 1'b0;

    // Reset during COL step 2 of the combinational instance.
    run_block(0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Fresh block after the discarded one.
    set_ramp(0); run_block(0);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
